uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one CoreUART transmit write port (CSN/WEN/DATA_IN, TXRDY) between
//  NUM_REQ byte-stream requesters. Round-robin, packet-atomic: a grant is held
//  until the granted requester's REQ_LAST beat is written. Sits between SoC
//  producers (debug console, telemetry, etc.) and the UART core, on the same clock.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..8)
//  WR_GAP    2    cycles after a UART write strobe during which UART_TXRDY is ignored
//  TIMEOUT   255  idle cycles tolerated mid-packet before forced release (macro only)
// PORTS
//  CLK          in   1          system clock, all logic on rising edge
//  RESET_N      in   1          synchronous, active-low reset
//  REQ_VALID    in   NUM_REQ    requester i has a byte on REQ_DATA[i]
//  REQ_DATA     in   NUM_REQ*8  byte of requester i at [8*i+7:8*i]
//  REQ_LAST     in   NUM_REQ    byte of requester i is the last of its packet
//  REQ_READY    out  NUM_REQ    byte of requester i accepted this cycle (comb.)
//  GRANT        out  NUM_REQ    one-hot current owner, registered; 0 when idle
//  BUSY         out  1          state != IDLE
//  UART_CSN     out  1          to UART CSN, active-low write strobe (registered)
//  UART_WEN     out  1          to UART WEN, identical to UART_CSN
//  UART_DATA    out  8          to UART DATA_IN, valid while strobe low
//  UART_TXRDY   in   1          from UART TXRDY
//  TIMEOUT_ERR  out  1          one-cycle pulse on forced release (0 without macro)
// BEHAVIOUR
//  Reset: state IDLE, GRANT=0, REQ_READY=0, BUSY=0, UART_CSN=UART_WEN=1,
//   UART_DATA=8'h00, TIMEOUT_ERR=0, rr pointer=0 (req 0 highest), gap cnt=0.
//  FSM states: IDLE, XFER, GAP.
//  IDLE: if any REQ_VALID, pick the first valid index at or after pointer
//   (wrapping); next cycle GRANT=onehot(pick), state XFER. Else stay.
//  XFER: REQ_READY[g] = REQ_VALID[g] & UART_TXRDY; all other bits are 0.
//   On accept: next cycle UART_CSN=UART_WEN=0 for exactly 1 cycle with
//   UART_DATA=REQ_DATA[g]; gap cnt<=WR_GAP; state GAP.
//  GAP: REQ_READY=0; gap cnt decrements; at 0 -> XFER, or if the accepted
//   beat had REQ_LAST -> IDLE with GRANT=0 and pointer=(g+1) mod NUM_REQ.
//  Latency: REQ_VALID seen in IDLE at cycle t -> GRANT at t+1 -> strobe
//   at t+2 (if TXRDY=1). Max one byte per WR_GAP+1 cycles.
//  UART_DATA holds its last value between strobes.
//  Non-granted REQ_VALID changes are ignored; no preemption ever.
//  REQ_VALID[g] dropping mid-packet: stay in XFER, wait (unbounded w/o macro).
//  Simultaneous requests: strictly round-robin, no starvation; one requester
//   alone is re-granted back to back, costing one IDLE cycle per packet.
//  RESET_N low in any state: next edge reaches reset values; a pending strobe
//   is cancelled; the partial packet is abandoned.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: in XFER a counter counts cycles with
//   REQ_VALID[g]=0 and clears on accept; at TIMEOUT -> IDLE, GRANT=0,
//   pointer=g+1, TIMEOUT_ERR pulses 1 cycle.
//  Undefined: no counter; TIMEOUT_ERR tied 0; grant waits indefinitely.
// STRUCTURE
//  Package uart_arb_pkg: state encoding (IDLE=2'b00, XFER=2'b01, GAP=2'b10),
//   IDX_W = $clog2(NUM_REQ) helper, strobe polarity constant.
//  Sub-module uart_arb_rr_pick: combinational round-robin selector
//   (valid vector + pointer -> one-hot pick + index + any).
//  FSM, gap/timeout counters and UART output registers live in the top.
// TESTING
//  1 Single req0 packet 3'h41,42,43(LAST), TXRDY=1 -> strobes at t+2, t+5,
//    t+8 with data 41,42,43; GRANT=4'b0001 until the GAP after 43 ends, then 0.
//  2 req0..3 all valid with 1-byte LAST packets -> grants in order 0,1,2,3;
//    then req2 again with req0 valid -> req2 not granted before req0
//    (pointer behaviour confirmed).
//  3 TXRDY held 0 for 20 cycles during XFER -> no strobe, REQ_READY=0;
//    TXRDY=1 -> strobe next cycle with the held byte.
//  4 req1 mid-packet, req2 valid -> req2 REQ_READY stays 0 until req1 LAST
//    is accepted; no interleaved bytes at UART_DATA.
//  5 RESET_N low 1 cycle during GAP -> all outputs reset values next edge,
//    UART_CSN=1, pointer 0; req3 then granted only if req0-2 are idle.
//  6 (macro on, TIMEOUT=8) req0 drops VALID after byte 1 -> TIMEOUT_ERR
//    pulse at cycle 8 idle, GRANT=0; req1 pending -> granted next.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// UART strobe polarity and width helpers.
package uart_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_GAP  = 2'b10
  } arb_state_e;

  // CoreUART CSN/WEN are active-low write strobes
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  // Index width for n requesters ($clog2, never below 1 bit)
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a down/up counter that must hold the value maxval
  function automatic int cnt_w(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin selector: returns the first valid requester
// at or after the pointer, wrapping around the vector.
module uart_arb_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  // Scan from the farthest offset down to the pointer so the nearest valid wins
  always_comb begin
    logic [IDX_W-1:0] w_j;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = |i_valid;
    w_j      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (i_valid[w_j]) begin
        o_onehot      = '0;
        o_onehot[w_j] = 1'b1;
        o_idx         = w_j;
      end else begin
        o_idx = o_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one CoreUART transmit write port
// between NUM_REQ byte-stream requesters. A grant is held until the owner's
// last beat has been written and the post-write gap has elapsed.
// Optional feature macro: UART_ARB_TIMEOUT_EN -- forced release of a grant
// after TIMEOUT idle cycles mid-packet, flagged by a TIMEOUT_ERR pulse.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WR_GAP  = 2
`ifdef UART_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_uart_csn,
  output logic                 o_uart_wen,
  output logic [7:0]           o_uart_data,
  input  logic                 i_uart_txrdy,
  output logic                 o_timeout_err
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int GAP_W = cnt_w(WR_GAP);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [NUM_REQ-1:0]  r_grant;
  logic [IDX_W-1:0]    r_gidx;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    w_ptr_next;
  logic [GAP_W-1:0]    r_gap;
  logic                r_last;
  logic                r_csn;
  logic [7:0]          r_data;
  logic                w_accept;
  logic                w_gap_done;
  logic                w_timeout;
  logic [NUM_REQ-1:0]  w_pick_onehot;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;

  uart_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_valid  (i_req_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // Pointer moves just past the owner when its packet ends or is abandoned
  assign w_ptr_next = (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : (r_gidx + IDX_W'(1));

  // FSM next-state and combinational ready; ready is masked while reset is
  // asserted so that no requester sees a beat accepted that is then discarded
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = '0;
    w_accept    = 1'b0;
    w_gap_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ST_XFER;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (i_req_valid[r_gidx] && i_uart_txrdy && i_reset_n) begin
          o_req_ready[r_gidx] = 1'b1;
          w_accept            = 1'b1;
          w_state_nxt         = ST_GAP;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_XFER;
        end
      end
      ST_GAP: begin
        if (r_gap <= GAP_W'(1)) begin
          w_gap_done  = 1'b1;
          w_state_nxt = r_last ? ST_IDLE : ST_XFER;
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant ownership and round-robin pointer
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
    end else if ((r_state == ST_IDLE) && w_pick_any) begin
      r_grant <= w_pick_onehot;
      r_gidx  <= w_pick_idx;
    end else if ((w_gap_done && r_last) || w_timeout) begin
      r_grant <= '0;
      r_ptr   <= w_ptr_next;
    end else begin
      r_grant <= r_grant;
    end
  end

  // Post-write gap counter and packet-end flag of the accepted beat
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_gap  <= '0;
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_gap  <= GAP_W'(WR_GAP);
      r_last <= i_req_last[r_gidx];
    end else if ((r_state == ST_GAP) && (r_gap != GAP_W'(0))) begin
      r_gap <= r_gap - GAP_W'(1);
    end else begin
      r_gap <= r_gap;
    end
  end

  // UART write strobe (one cycle per accepted beat) and held data byte
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_csn  <= STROBE_OFF;
      r_data <= 8'h00;
    end else if (w_accept) begin
      r_csn  <= STROBE_ON;
      r_data <= i_req_data[{r_gidx, 3'b000} +: 8];
    end else begin
      r_csn <= STROBE_OFF;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = cnt_w(TIMEOUT);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_terr;

  assign w_timeout = (r_state == ST_XFER) && !i_req_valid[r_gidx] &&
                     (r_to_cnt == TO_W'(TIMEOUT - 1));

  // Count owner-idle cycles in XFER; a forced release raises a one-cycle flag
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_to_cnt <= '0;
      r_terr   <= 1'b0;
    end else begin
      r_terr <= w_timeout;
      if ((r_state != ST_XFER) || w_accept || w_timeout) begin
        r_to_cnt <= '0;
      end else if (!i_req_valid[r_gidx]) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= r_to_cnt;
      end
    end
  end

  assign o_timeout_err = r_terr;
`else
  assign w_timeout     = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  assign o_grant     = r_grant;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_uart_csn  = r_csn;
  assign o_uart_wen  = r_csn;
  assign o_uart_data = r_data;

endmodule
